// File: rtl/dff_pipe_pkg.sv
// rtl/dff_pipe_pkg.sv - shared types and helpers for the dff_pipeline register pipeline
// DFF_PIPE_PARITY_EN adds a stored parity bit to every stage record.
package dff_pipe_pkg;

   localparam int unsigned DFF_PIPE_RESET_VAL = 0;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic valid;
`ifdef DFF_PIPE_PARITY_EN
      logic parity;
`endif
   } stage_rec_t;

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one pipeline register stage (valid/data, parity with DFF_PIPE_PARITY_EN)
// Flush clears the control record only; data is left as-is since invalid data is don't-care.
module dff_pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             load,
   input  stage_rec_t       d_rec,
   input  logic [WIDTH-1:0] d_data,
   output stage_rec_t       q_rec,
   output logic [WIDTH-1:0] q_data
);

   stage_rec_t clr_rec;

   always_comb begin
      clr_rec = '0;
`ifdef DFF_PIPE_PARITY_EN
      clr_rec.parity = ^RESET_VAL;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_rec  <= clr_rec;
         q_data <= RESET_VAL;
      end else if (flush) begin
         q_rec  <= clr_rec;
      end else if (load) begin
         q_rec  <= d_rec;
         q_data <= d_data;
      end
   end

endmodule

// File: rtl/dff_pipeline.sv
// rtl/dff_pipeline.sv - WIDTH x DEPTH valid/ready register pipeline with bubble collapse and flush
// Optional DFF_PIPE_PARITY_EN: per-stage even parity and out_perr output.
module dff_pipeline
   import dff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_PIPE_RESET_VAL),
   localparam int              CNT_W     = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef DFF_PIPE_PARITY_EN
   output logic             out_perr,
`endif
   output logic [CNT_W-1:0] count
);

   // Index 0 is the producer side; index i+1 is the output of stage i.
   stage_rec_t       chain_rec  [DEPTH+1];
   logic [WIDTH-1:0] chain_data [DEPTH+1];
   logic [DEPTH:0]   rdy;
   logic             in_fire;
   logic             out_fire;

   always_comb begin
      chain_rec[0]       = '0;
      chain_rec[0].valid = in_valid;
`ifdef DFF_PIPE_PARITY_EN
      chain_rec[0].parity = ^in_data;
`endif
   end
   assign chain_data[0] = in_data;
   assign rdy[DEPTH]    = out_ready;

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_stage
         // A stage may load when empty or when its successor moves this cycle.
         assign rdy[i] = !chain_rec[i+1].valid || rdy[i+1];

         dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush),
            .load   (rdy[i]),
            .d_rec  (chain_rec[i]),
            .d_data (chain_data[i]),
            .q_rec  (chain_rec[i+1]),
            .q_data (chain_data[i+1])
         );
      end
   endgenerate

   assign in_ready  = rdy[0];
   assign out_valid = chain_rec[DEPTH].valid;
   assign out_data  = chain_data[DEPTH];
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

`ifdef DFF_PIPE_PARITY_EN
   assign out_perr = out_valid && ((^out_data) != chain_rec[DEPTH].parity);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (in_fire && !out_fire) begin
         count <= count + CNT_W'(1);
      end else if (out_fire && !in_fire) begin
         count <= count - CNT_W'(1);
      end
   end

endmodule
